fan831_arb: RTL and testbench
=============================

FAN831_ARB -- requirements
Module: fan831_arb

Interface
REQ-001 SHALL have parameter SIGNAL_WIDTH, default `REG_WIDTH (8), the data width of every channel.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have ports in0..in7, input, SIGNAL_WIDTH each: source data, one per channel.
REQ-005 SHALL have port in_valid, input, 8 bits: bit i set means in<i> holds a word to deliver.
REQ-006 SHALL have port in_ready, output, 8 bits: bit i set means channel i's word is taken this cycle.
REQ-007 SHALL have port out, output reg, SIGNAL_WIDTH: the merged data word.
REQ-008 SHALL have port out_valid, output reg, 1 bit: out holds an undelivered word.
REQ-009 SHALL have port out_ready, input, 1 bit: the sink accepts out this cycle.
REQ-010 SHALL have port out_sel, output reg, 3 bits: index of the channel that supplied out.

Function
REQ-011 SHALL define a transfer on channel i as in_valid[i] and in_ready[i] both high at a clk edge.
REQ-012 SHALL define a delivery as out_valid and out_ready both high at a clk edge.
REQ-013 SHALL define load_en = !out_valid || out_ready.
REQ-014 SHALL compute in_ready combinationally: at most one bit high, and only when load_en is high.
REQ-015 SHALL grant by round-robin: search channels from (last_grant+1) mod 8 upward with wrap-around; grant the first channel with in_valid set.
REQ-016 SHALL, on a transfer from channel i, register in<i> into out and i into out_sel, set out_valid=1 and set last_grant=i, all on the same edge.
REQ-017 SHALL clear out_valid on a delivery when no transfer occurs on the same edge.
REQ-018 SHALL, when a delivery and a transfer coincide, load the new word with out_valid staying 1, so full throughput is one word per cycle.
REQ-019 SHALL, while out_valid=1 and out_ready=0, hold out, out_sel and last_grant stable and drive in_ready=0.
REQ-020 SHALL give a latency of one cycle from transfer to out_valid high.
REQ-021 SHALL leave last_grant unchanged in any cycle with no grant.
REQ-022 SHALL, with a single requester, grant it on every load_en cycle (no idle bubbles).
REQ-023 SHALL bound starvation: a channel held valid is granted within 8 load_en cycles.
REQ-024 SHALL not require sources to hold in<i> after their transfer edge.

Reset
REQ-025 SHALL, while rst=1, force out=0, out_sel=0, out_valid=0, last_grant=7 (so channel 0 has first priority) and in_ready=0, independent of clk.
REQ-026 SHALL discard any word held in out, undelivered, when rst asserts mid-operation.
REQ-027 SHALL make no grant on the first clk edge after rst deasserts if no in_valid bit is set.

Structure
REQ-028 SHALL take REG_WIDTH from the shared definitions header, which also holds the 3-bit channel-index width constant; no new package types.
REQ-029 SHALL place the round-robin search in sub-module rr_arb8 (inputs req[7:0], last[2:0]; outputs grant one-hot, grant_idx, any); fan831_arb instantiates it once.
REQ-030 SHALL be guarded against multiple inclusion in the same way as other design files.

Verification
REQ-031 Single source: in_valid=8'h04, in2=8'hA5, out_ready=1 -> edge 1: out=A5, out_sel=2, out_valid=1; in_ready=8'h04 every cycle.
REQ-032 All valid: in_valid=8'hFF, out_ready=1 from reset -> out_sel sequence 0,1,2,...,7,0 on consecutive cycles.
REQ-033 Backpressure: out_valid=1 with out=3C, out_ready=0 for 4 cycles, in_valid=8'h81 -> out stays 3C, in_ready=0 throughout; out_ready=1 -> next word from channel 7 if last_grant=0.
REQ-034 Wrap: last_grant=6, in_valid=8'h41 -> channel 0 granted before channel 6 is granted again.
REQ-035 Reset mid-operation: out_valid=1, out=77, assert rst between edges -> out=0, out_valid=0 immediately; after release with in_valid=8'h03, channel 0 is granted first.
REQ-036 Simultaneous: out_valid=1, out_ready=1, in_valid=8'h10, in4=8'h5A -> out=5A, out_valid stays 1, no bubble.

Source files
------------

// File: rtl/fan831_arb_pkg.sv
// ============================================================================
//  fan831_arb_pkg : shared widths for the 8:1 round-robin fan-in arbiter
//  Revision 1.0
// ============================================================================
`ifndef FAN831_ARB_PKG_SV
`define FAN831_ARB_PKG_SV
`default_nettype none

package fan831_arb_pkg;
  localparam int REG_WIDTH = 8;
  localparam int CH_IDX_W  = 3;
  localparam int NUM_CH    = 8;
endpackage

`default_nettype wire
`endif

// File: rtl/fan831_arb_rr_arb8.sv
// ============================================================================
//  rr_arb8 : 8-way round-robin search starting just after the last grant
//  Revision 1.0
// ============================================================================
`ifndef FAN831_ARB_RR_ARB8_SV
`define FAN831_ARB_RR_ARB8_SV
`default_nettype none

module rr_arb8
  import fan831_arb_pkg::*;
(
  input  logic [NUM_CH-1:0]   req,
  input  logic [CH_IDX_W-1:0] last,
  output logic [NUM_CH-1:0]   grant,
  output logic [CH_IDX_W-1:0] grant_idx,
  output logic                any
);

  logic [CH_IDX_W-1:0] idx;

  // Offset 8 wraps to 'last' itself, so a lone requester is always re-granted.
  always_comb begin
    grant     = '0;
    grant_idx = last;
    any       = 1'b0;
    idx       = last;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = last + CH_IDX_W'(k);
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
`endif

// File: rtl/fan831_arb.sv
// ============================================================================
//  fan831_arb : 8-channel valid/ready round-robin merge into one output register
//  Revision 1.0
// ============================================================================
`ifndef FAN831_ARB_SV
`define FAN831_ARB_SV
`default_nettype none

module fan831_arb
  import fan831_arb_pkg::*;
#(
  parameter int SIGNAL_WIDTH = REG_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SIGNAL_WIDTH-1:0] in0,
  input  logic [SIGNAL_WIDTH-1:0] in1,
  input  logic [SIGNAL_WIDTH-1:0] in2,
  input  logic [SIGNAL_WIDTH-1:0] in3,
  input  logic [SIGNAL_WIDTH-1:0] in4,
  input  logic [SIGNAL_WIDTH-1:0] in5,
  input  logic [SIGNAL_WIDTH-1:0] in6,
  input  logic [SIGNAL_WIDTH-1:0] in7,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [SIGNAL_WIDTH-1:0] out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_IDX_W-1:0]     out_sel
);

  logic [SIGNAL_WIDTH-1:0] out_q, out_d;
  logic [CH_IDX_W-1:0]     out_sel_q, out_sel_d;
  logic                    out_valid_q, out_valid_d;
  logic [CH_IDX_W-1:0]     last_grant_q, last_grant_d;

  logic [NUM_CH-1:0]       grant;
  logic [CH_IDX_W-1:0]     grant_idx;
  logic                    grant_any;
  logic                    load_en;
  logic                    transfer;
  logic [SIGNAL_WIDTH-1:0] sel_data;

  rr_arb8 u_rr_arb8 (
    .req       (in_valid),
    .last      (last_grant_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign load_en  = !out_valid_q || out_ready;
  assign transfer = load_en && grant_any && !rst;
  // rst gates the handshake so nothing is taken while the register is being cleared.
  assign in_ready = (load_en && !rst) ? grant : '0;

  always_comb begin
    sel_data = in0;
    case (grant_idx)
      3'd0:    sel_data = in0;
      3'd1:    sel_data = in1;
      3'd2:    sel_data = in2;
      3'd3:    sel_data = in3;
      3'd4:    sel_data = in4;
      3'd5:    sel_data = in5;
      3'd6:    sel_data = in6;
      3'd7:    sel_data = in7;
      default: sel_data = in0;
    endcase
  end

  always_comb begin
    out_d        = out_q;
    out_sel_d    = out_sel_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (transfer) begin
      out_d        = sel_data;
      out_sel_d    = grant_idx;
      out_valid_d  = 1'b1;
      last_grant_d = grant_idx;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      out_sel_q    <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= 3'd7;
    end else begin
      out_q        <= out_d;
      out_sel_q    <= out_sel_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out       = out_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire
`endif

// File: tb/tb_fan831_arb.sv
// ============================================================================
//  tb_fan831_arb : directed table plus corner sequences for fan831_arb
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_fan831_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic [7:0] in_valid;
  logic [7:0] in_ready;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_sel;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fan831_arb #(.SIGNAL_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .in5       (in5),
    .in6       (in6),
    .in7       (in7),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  typedef struct {
    logic [7:0] iv;
    logic       ordy;
    logic [7:0] base;
    logic [7:0] e_irdy;
    logic       e_ov;
    logic [2:0] e_sel;
    logic [7:0] e_out;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Channel i carries base+i so the expected word follows from the granted index.
  task automatic set_data(input logic [7:0] base);
    in0 = base;         in1 = base + 8'd1; in2 = base + 8'd2; in3 = base + 8'd3;
    in4 = base + 8'd4;  in5 = base + 8'd5; in6 = base + 8'd6; in7 = base + 8'd7;
  endtask

  task automatic step(input string nm, input logic [7:0] iv, input logic ordy,
                      input logic [7:0] base, input logic [7:0] e_irdy,
                      input logic e_ov, input logic [2:0] e_sel, input logic [7:0] e_out);
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    set_data(base);
    #1;
    check({nm, ".in_ready"}, in_ready, e_irdy);
    @(posedge clk);
    #1;
    check({nm, ".out_valid"}, 8'(out_valid), 8'(e_ov));
    check({nm, ".out_sel"}, 8'(out_sel), 8'(e_sel));
    check({nm, ".out"}, out, e_out);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 8'h00;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{8'h04, 1'b1, 8'hA3, 8'h04, 1'b1, 3'd2, 8'hA5};
    vecs[1]  = '{8'h04, 1'b1, 8'hA3, 8'h04, 1'b1, 3'd2, 8'hA5};
    vecs[2]  = '{8'h00, 1'b1, 8'hA3, 8'h00, 1'b0, 3'd2, 8'hA5};
    vecs[3]  = '{8'hFF, 1'b1, 8'h00, 8'h08, 1'b1, 3'd3, 8'h03};
    vecs[4]  = '{8'hFF, 1'b0, 8'h00, 8'h00, 1'b1, 3'd3, 8'h03};
    vecs[5]  = '{8'hFF, 1'b0, 8'h00, 8'h00, 1'b1, 3'd3, 8'h03};
    vecs[6]  = '{8'hFF, 1'b1, 8'h00, 8'h10, 1'b1, 3'd4, 8'h04};
    vecs[7]  = '{8'h41, 1'b1, 8'h00, 8'h40, 1'b1, 3'd6, 8'h06};
    vecs[8]  = '{8'h41, 1'b1, 8'h00, 8'h01, 1'b1, 3'd0, 8'h00};
    vecs[9]  = '{8'h41, 1'b1, 8'h00, 8'h40, 1'b1, 3'd6, 8'h06};
    vecs[10] = '{8'h10, 1'b1, 8'h56, 8'h10, 1'b1, 3'd4, 8'h5A};
    vecs[11] = '{8'h00, 1'b0, 8'h56, 8'h00, 1'b1, 3'd4, 8'h5A};
    vecs[12] = '{8'h00, 1'b1, 8'h56, 8'h00, 1'b0, 3'd4, 8'h5A};

    // Reset state, asserted before any clock edge and with every source requesting.
    rst       = 1'b1;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    set_data(8'h11);
    #2;
    check("rst.out", out, 8'h00);
    check("rst.out_valid", 8'(out_valid), 8'h00);
    check("rst.out_sel", 8'(out_sel), 8'h00);
    check("rst.in_ready", in_ready, 8'h00);

    // Release with nothing requesting: the first edge must not grant.
    @(negedge clk);
    in_valid = 8'h00;
    rst      = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_rst.out_valid", 8'(out_valid), 8'h00);

    for (int i = 0; i < 13; i++)
      step($sformatf("vec%0d", i), vecs[i].iv, vecs[i].ordy, vecs[i].base,
           vecs[i].e_irdy, vecs[i].e_ov, vecs[i].e_sel, vecs[i].e_out);

    // All channels valid from reset: strict rotation 0..7 then back to 0.
    do_reset();
    for (int k = 0; k < 9; k++)
      step($sformatf("rot%0d", k), 8'hFF, 1'b1, 8'h80, 8'(1 << (k % 8)),
           1'b1, 3'(k % 8), 8'h80 + 8'(k % 8));

    // Backpressure: word 3C from channel 0 held while the sink stalls.
    do_reset();
    step("bp_load", 8'h01, 1'b0, 8'h3C, 8'h01, 1'b1, 3'd0, 8'h3C);
    for (int k = 0; k < 4; k++)
      step($sformatf("bp_hold%0d", k), 8'h81, 1'b0, 8'h3C, 8'h00, 1'b1, 3'd0, 8'h3C);
    step("bp_release", 8'h81, 1'b1, 8'h3C, 8'h80, 1'b1, 3'd7, 8'h43);

    // Asynchronous reset between edges discards the pending word.
    do_reset();
    step("mid_load", 8'h01, 1'b0, 8'h77, 8'h01, 1'b1, 3'd0, 8'h77);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst.out", out, 8'h00);
    check("mid_rst.out_valid", 8'(out_valid), 8'h00);
    check("mid_rst.in_ready", in_ready, 8'h00);
    #1;
    rst       = 1'b0;
    in_valid  = 8'h03;
    out_ready = 1'b1;
    set_data(8'h20);
    #1;
    check("post_rst.in_ready", in_ready, 8'h01);
    @(posedge clk);
    #1;
    check("post_rst.out_sel", 8'(out_sel), 8'h00);
    check("post_rst.out", out, 8'h20);
    check("post_rst.out_valid", 8'(out_valid), 8'h01);
    step("post_rst_next", 8'h03, 1'b1, 8'h20, 8'h02, 1'b1, 3'd1, 8'h21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
